// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format codes, field geometry and fit helpers for the immediate field encoder
package imm_pkg;

   typedef enum logic [1:0] {
      FMT_B    = 2'b00,
      FMT_RSVD = 2'b01,
      FMT_CB   = 2'b10,
      FMT_D    = 2'b11
   } fmt_e;

   localparam int W_D  = 9;
   localparam int W_CB = 19;
   localparam int W_B  = 26;

   localparam int LSB_D  = 12;
   localparam int LSB_CB = 5;
   localparam int LSB_B  = 0;

   // Field width selected by a format code; the reserved code never uses its result.
   function automatic int field_width(input logic [1:0] fmt);
      case (fmt)
         FMT_D:   return W_D;
         FMT_CB:  return W_CB;
         default: return W_B;
      endcase
   endfunction

   // Fits in a signed field of w bits iff imm[63:w-1] is all copies of the sign bit.
   function automatic logic field_fits(input logic [63:0] imm, input int w);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (i >= w - 1 && imm[i] != imm[63]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/imm_field_encoder_if.sv
// rtl/imm_field_encoder_if.sv - input/output handshake bundle for the immediate field encoder
interface imm_field_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_fmt;
   logic [31:0] in_base;
   logic [63:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_range_err;
   logic        out_fmt_err;

   modport master (
      output in_valid, in_fmt, in_base, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_range_err, out_fmt_err
   );

   modport slave (
      input  in_valid, in_fmt, in_base, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_range_err, out_fmt_err
   );
endinterface

// File: rtl/imm_field_pack.sv
// rtl/imm_field_pack.sv - combinational field packer; IMM_SATURATE_EN selects clamping over truncation
module imm_field_pack
   import imm_pkg::*;
(
   input  logic [1:0]  fmt,
   input  logic [31:0] base,
   input  logic [63:0] imm,
   input  logic        fit,
   output logic [31:0] instr,
   output logic        range_err,
   output logic        fmt_err
);

   logic [W_D-1:0]  f_d;
   logic [W_CB-1:0] f_cb;
   logic [W_B-1:0]  f_b;

   // Upper immediate bits only matter through the precomputed fit flag.
   logic unused_imm_hi;
   assign unused_imm_hi = ^imm[63:W_B];

`ifdef IMM_SATURATE_EN
   assign f_d  = fit ? imm[W_D-1:0]
               : (imm[63] ? {1'b1, {(W_D-1){1'b0}}}  : {1'b0, {(W_D-1){1'b1}}});
   assign f_cb = fit ? imm[W_CB-1:0]
               : (imm[63] ? {1'b1, {(W_CB-1){1'b0}}} : {1'b0, {(W_CB-1){1'b1}}});
   assign f_b  = fit ? imm[W_B-1:0]
               : (imm[63] ? {1'b1, {(W_B-1){1'b0}}}  : {1'b0, {(W_B-1){1'b1}}});
`else
   assign f_d  = imm[W_D-1:0];
   assign f_cb = imm[W_CB-1:0];
   assign f_b  = imm[W_B-1:0];
`endif

   // Splice the field into the base word and force the format bits; reserved code passes base through.
   always_comb begin
      instr     = base;
      range_err = 1'b0;
      fmt_err   = 1'b0;
      case (fmt)
         FMT_D: begin
            instr     = {FMT_D, base[29:LSB_D+W_D], f_d, base[LSB_D-1:0]};
            range_err = !fit;
         end
         FMT_CB: begin
            instr     = {FMT_CB, base[29:LSB_CB+W_CB], f_cb, base[LSB_CB-1:0]};
            range_err = !fit;
         end
         FMT_B: begin
            instr     = {FMT_B, base[29:LSB_B+W_B], f_b};
            range_err = !fit;
         end
         default: begin
            fmt_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_field_encoder.sv
// rtl/imm_field_encoder.sv - two-stage immediate field encoder with error counter (IMM_SATURATE_EN clamps overflow)
module imm_field_encoder
   import imm_pkg::*;
#(
   parameter int ERR_CNT_W = 16
)
(
   input  logic                 clock,
   input  logic                 reset_n,
   imm_field_encoder_if.slave   bus,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic        s1_valid;
   logic [1:0]  s1_fmt;
   logic [31:0] s1_base;
   logic [63:0] s1_imm;
   logic        s1_fit;

   logic        s2_valid;
   logic [31:0] s2_instr;
   logic        s2_range_err;
   logic        s2_fmt_err;

   logic [ERR_CNT_W-1:0] err_cnt;

   logic        s1_adv;
   logic        s2_adv;
   logic        in_fit;
   logic [31:0] pk_instr;
   logic        pk_range_err;
   logic        pk_fmt_err;

   assign s2_adv      = !s2_valid || bus.out_ready;
   assign s1_adv      = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;

   assign in_fit = field_fits(bus.in_imm, field_width(bus.in_fmt));

   // Stage 1: capture the beat and its fit flag whenever the stage can advance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_fmt   <= 2'b00;
         s1_base  <= 32'h0;
         s1_imm   <= 64'h0;
         s1_fit   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_fmt  <= bus.in_fmt;
            s1_base <= bus.in_base;
            s1_imm  <= bus.in_imm;
            s1_fit  <= in_fit;
         end
      end
   end

   imm_field_pack u_pack (
      .fmt       (s1_fmt),
      .base      (s1_base),
      .imm       (s1_imm),
      .fit       (s1_fit),
      .instr     (pk_instr),
      .range_err (pk_range_err),
      .fmt_err   (pk_fmt_err)
   );

   // Stage 2: register the packed word and flags; held while downstream stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid     <= 1'b0;
         s2_instr     <= 32'h0;
         s2_range_err <= 1'b0;
         s2_fmt_err   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_instr     <= pk_instr;
            s2_range_err <= pk_range_err;
            s2_fmt_err   <= pk_fmt_err;
         end
      end
   end

   // Count erroring beats as they leave, stopping at all-ones.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt <= '0;
      end else if (s2_valid && bus.out_ready && (s2_range_err || s2_fmt_err)
                   && (err_cnt != {ERR_CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   assign bus.out_valid     = s2_valid;
   assign bus.out_instr     = s2_instr;
   assign bus.out_range_err = s2_range_err;
   assign bus.out_fmt_err   = s2_fmt_err;
   assign err_count         = err_cnt;

endmodule

// File: tb/tb_imm_field_encoder.sv
// tb/tb_imm_field_encoder.sv - directed self-checking bench for imm_field_encoder
module tb_imm_field_encoder;

   logic        clock;
   logic        reset_n;
   logic [15:0] err_count;
   logic [1:0]  err_count2;

   int checks = 0;
   int errors = 0;
   int exp_err = 0;

   imm_field_encoder_if bus ();
   imm_field_encoder_if bus2 ();

   imm_field_encoder #(.ERR_CNT_W(16)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .err_count (err_count)
   );

   imm_field_encoder #(.ERR_CNT_W(2)) dut2 (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus2),
      .err_count (err_count2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One beat through an empty pipeline with out_ready held high.
   task automatic run_one(input string tag, input logic [1:0] fmt, input logic [31:0] base,
                          input logic [63:0] imm, input logic [31:0] exp_instr,
                          input logic exp_r, input logic exp_f);
      @(negedge clock);
      bus.in_valid  = 1'b1;
      bus.in_fmt    = fmt;
      bus.in_base   = base;
      bus.in_imm    = imm;
      bus.out_ready = 1'b1;
      #1 check({tag, "_in_ready"}, bus.in_ready, 1);
      @(negedge clock);
      bus.in_valid = 1'b0;
      check({tag, "_lat1_valid"}, bus.out_valid, 0);
      @(negedge clock);
      check({tag, "_lat2_valid"}, bus.out_valid, 1);
      check({tag, "_instr"}, bus.out_instr, exp_instr);
      check({tag, "_range_err"}, bus.out_range_err, exp_r);
      check({tag, "_fmt_err"}, bus.out_fmt_err, exp_f);
      if (exp_r || exp_f) exp_err++;
      @(negedge clock);
      check({tag, "_drained"}, bus.out_valid, 0);
      check({tag, "_err_count"}, err_count, exp_err);
   endtask

   initial begin
      int tx;
      int rx;
      logic [31:0] cb_exp;

      reset_n        = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_fmt     = 2'b00;
      bus.in_base    = 32'h0;
      bus.in_imm     = 64'h0;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.in_fmt    = 2'b01;
      bus2.in_base   = 32'h0;
      bus2.in_imm    = 64'h0;
      bus2.out_ready = 1'b1;

      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_err_count", err_count, 0);
      check("rst_out_instr", bus.out_instr, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_out_valid", bus.out_valid, 0);

      run_one("d_neg1", 2'b11, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef IMM_SATURATE_EN
      cb_exp = 32'h807F_FFE0;
`else
      cb_exp = 32'h8080_0000;
`endif
      run_one("cb_ovf", 2'b10, 32'h0, 64'h0000_0000_0004_0000, cb_exp, 1'b1, 1'b0);
      run_one("b_neg2", 2'b00, 32'h1400_0000, 64'hFFFF_FFFF_FFFF_FFFE, 32'h17FF_FFFE, 1'b0, 1'b0);
      run_one("rsvd", 2'b01, 32'h5555_AAAA, 64'h0, 32'h5555_AAAA, 1'b0, 1'b1);
      run_one("d_max", 2'b11, 32'h0, 64'h0000_0000_0000_00FF, 32'hC00F_F000, 1'b0, 1'b0);

      // Backpressure: four B-type beats, out_ready low for the first three edges.
      tx = 0;
      rx = 0;
      bus.in_fmt  = 2'b00;
      bus.in_base = 32'h0;
      for (int c = 0; c < 30 && rx < 4; c++) begin
         @(negedge clock);
         if (c == 3) check("bp_hold_instr_c3", bus.out_instr, 1);
         bus.out_ready = (c >= 3);
         bus.in_valid  = (tx < 4);
         bus.in_imm    = 64'(tx + 1);
         #1;
         if (c == 2) begin
            check("bp_full_in_ready", bus.in_ready, 0);
            check("bp_full_out_valid", bus.out_valid, 1);
            check("bp_hold_instr_c2", bus.out_instr, 1);
         end
         if (bus.in_valid && bus.in_ready) tx++;
         if (bus.out_valid && bus.out_ready) begin
            check("bp_order", bus.out_instr, 32'(rx + 1));
            rx++;
         end
         @(posedge clock);
      end
      bus.in_valid = 1'b0;
      check("bp_tx_count", tx, 4);
      check("bp_rx_count", rx, 4);
      @(negedge clock);
      check("bp_no_dup", bus.out_valid, 0);

      // Reset with beats in flight.
      @(negedge clock);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_fmt    = 2'b01;
      bus.in_base   = 32'h1234_5678;
      bus.in_imm    = 64'h0;
      @(negedge clock);
      @(negedge clock);
      bus.in_valid = 1'b0;
      #1 check("mid_pre_valid", bus.out_valid, 1);
      check("mid_pre_err_count", err_count, exp_err);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_err_count", err_count, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      exp_err = 0;
      @(negedge clock);
      reset_n       = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("mid_dropped", bus.out_valid, 0);
      check("mid_err_count_after", err_count, 0);

      // Saturation on the 2-bit counter instance: five erroring beats.
      tx = 0;
      rx = 0;
      for (int c = 0; c < 40 && rx < 5; c++) begin
         @(negedge clock);
         bus2.in_valid = (tx < 5);
         #1;
         if (bus2.in_valid && bus2.in_ready) tx++;
         if (bus2.out_valid && bus2.out_ready) rx++;
         @(posedge clock);
      end
      bus2.in_valid = 1'b0;
      @(negedge clock);
      check("sat_rx_count", rx, 5);
      check("sat_err_count", err_count2, 3);
      check("sat_main_untouched", err_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
